day_alarm: RTL and testbench

//   Alarm stage downstream of the day clock. Consumes the clock's hr/min/sec values and its
//   1 Hz tick. Holds a settable alarm time (HH:MM) and rings when the clock reaches HH:MM:00.

---
 rtl/day_alarm.sv | 187 ++++++++++++++++++
 tb/tb_day_alarm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/day_alarm.sv
// -----------------------------------------------------------------------------
// day_alarm
//   Alarm stage that sits after the day clock. It watches the clock's hr/min/sec
//   values and its 1 Hz tick. It holds a settable alarm time (HH:MM) and starts
//   ringing when the clock reaches HH:MM:00.
//
//   The alarm supports a limited number of snoozes, a dismiss input and an
//   automatic timeout. While ringing, LEDR blinks all-ones / all-zeros.
//
// Ports
//   CLOCK_50    in   1   system clock, all logic on posedge
//   reset       in   1   synchronous, active-high reset
//   hr/min/sec  in       current time from the day clock
//   sec_tick    in   1   1-cycle pulse, presented together with the new sec value
//   set_time    in   8   value to load into the alarm hour or minute
//   set_strobe  in   1   1-cycle load pulse
//   set_sel     in   1   0 = load alarm minute, 1 = load alarm hour
//   alarm_en    in   1   level; low disarms the alarm and forces IDLE
//   snooze      in   1   level button, edge-detected here
//   dismiss     in   1   level; high stops the current alarm event
//   alarm_hr    out  5   stored alarm hour
//   alarm_min   out  6   stored alarm minute
//   ringing     out  1   high in RINGING
//   snoozing    out  1   high in SNOOZE
//   LEDR        out  10  blink pattern while ringing, otherwise 0
// -----------------------------------------------------------------------------
module day_alarm #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [4:0] hr,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       sec_tick,
  input  logic [7:0] set_time,
  input  logic       set_strobe,
  input  logic       set_sel,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       dismiss,
  output logic [4:0] alarm_hr,
  output logic [5:0] alarm_min,
  output logic       ringing,
  output logic       snoozing,
  output logic [9:0] LEDR
);

  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = $clog2(SNOOZE_SECS + 1);
  localparam int UW = $clog2(MAX_SNOOZE + 1);

  localparam logic [RW-1:0] RING_LOAD = RW'(RING_SECS);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SECS);
  localparam logic [UW-1:0] SNZ_MAX   = UW'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic [UW-1:0] snz_used_q, snz_used_d;
  logic [9:0]    ledr_q, ledr_d;
  logic [4:0]    alarm_hr_q, alarm_hr_d;
  logic [5:0]    alarm_min_q, alarm_min_d;
  logic          snooze_d_q;

  logic snooze_edge;
  logic time_match;

  assign snooze_edge = snooze & ~snooze_d_q;
  assign time_match  = sec_tick && (hr == alarm_hr_q) && (min == alarm_min_q) &&
                       (sec == 6'd0);

  // Alarm time load. Values out of range are dropped so the stored time
  // is always a legal HH:MM.
  always_comb begin
    alarm_hr_d  = alarm_hr_q;
    alarm_min_d = alarm_min_q;
    if (set_strobe) begin
      if (set_sel) begin
        if (set_time < 8'd24) alarm_hr_d = set_time[4:0];
      end else begin
        if (set_time < 8'd60) alarm_min_d = set_time[5:0];
      end
    end
  end

  // Next-state logic. Priority: alarm_en low > dismiss > snooze edge > tick.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    snz_used_d = snz_used_q;
    ledr_d     = ledr_q;

    if (!alarm_en) begin
      state_d = IDLE;
      ledr_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          ledr_d = '0;
          if (time_match) begin
            state_d    = RINGING;
            ring_cnt_d = RING_LOAD;
            snz_used_d = '0;
            ledr_d     = '1;
          end
        end
        RINGING: begin
          if (dismiss) begin
            state_d = IDLE;
            ledr_d  = '0;
          end else if (snooze_edge && (snz_used_q < SNZ_MAX)) begin
            state_d    = SNOOZE;
            snz_cnt_d  = SNZ_LOAD;
            snz_used_d = snz_used_q + UW'(1);
            ledr_d     = '0;
          end else if (sec_tick) begin
            if (ring_cnt_q == RW'(1)) begin
              state_d = IDLE;
              ledr_d  = '0;
            end else begin
              ring_cnt_d = ring_cnt_q - RW'(1);
              ledr_d     = ~ledr_q;
            end
          end
        end
        SNOOZE: begin
          if (dismiss) begin
            state_d = IDLE;
            ledr_d  = '0;
          end else if (sec_tick) begin
            if (snz_cnt_q == SW'(1)) begin
              state_d    = RINGING;
              ring_cnt_d = RING_LOAD;
              ledr_d     = '1;
            end else begin
              snz_cnt_d = snz_cnt_q - SW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          ledr_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      ring_cnt_q  <= '0;
      snz_cnt_q   <= '0;
      snz_used_q  <= '0;
      ledr_q      <= '0;
      alarm_hr_q  <= '0;
      alarm_min_q <= '0;
      // Pre-set high so a button held through reset is not seen as a press.
      snooze_d_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      ring_cnt_q  <= ring_cnt_d;
      snz_cnt_q   <= snz_cnt_d;
      snz_used_q  <= snz_used_d;
      ledr_q      <= ledr_d;
      alarm_hr_q  <= alarm_hr_d;
      alarm_min_q <= alarm_min_d;
      snooze_d_q  <= snooze;
    end
  end

  assign alarm_hr  = alarm_hr_q;
  assign alarm_min = alarm_min_q;
  assign ringing   = (state_q == RINGING);
  assign snoozing  = (state_q == SNOOZE);
  assign LEDR      = ledr_q;

endmodule

// File: tb/tb_day_alarm.sv
// -----------------------------------------------------------------------------
// tb_day_alarm
//   Directed bench for day_alarm with RING_SECS=5, SNOOZE_SECS=4 and
//   MAX_SNOOZE=2. Inputs change on the falling edge. Outputs are checked on the
//   falling edge, one cycle after the cause.
// -----------------------------------------------------------------------------
module tb_day_alarm;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] hr;
  logic [5:0] min;
  logic [5:0] sec;
  logic       sec_tick;
  logic [7:0] set_time;
  logic       set_strobe;
  logic       set_sel;
  logic       alarm_en;
  logic       snooze;
  logic       dismiss;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       ringing;
  logic       snoozing;
  logic [9:0] LEDR;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  day_alarm #(
    .RING_SECS  (5),
    .SNOOZE_SECS(4),
    .MAX_SNOOZE (2)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .hr        (hr),
    .min       (min),
    .sec       (sec),
    .sec_tick  (sec_tick),
    .set_time  (set_time),
    .set_strobe(set_strobe),
    .set_sel   (set_sel),
    .alarm_en  (alarm_en),
    .snooze    (snooze),
    .dismiss   (dismiss),
    .alarm_hr  (alarm_hr),
    .alarm_min (alarm_min),
    .ringing   (ringing),
    .snoozing  (snoozing),
    .LEDR      (LEDR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_tick(input int h, input int m, input int s);
    hr = 5'(h); min = 6'(m); sec = 6'(s); sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0;
  endtask

  task automatic set_alarm(input logic sel, input int val);
    set_sel = sel; set_time = 8'(val); set_strobe = 1'b1;
    cyc();
    set_strobe = 1'b0;
  endtask

  task automatic press_snooze();
    snooze = 1'b1;
    cyc();
    snooze = 1'b0;
  endtask

  initial begin
    reset = 1'b1; hr = '0; min = '0; sec = 6'd1; sec_tick = 1'b0;
    set_time = '0; set_strobe = 1'b0; set_sel = 1'b0;
    alarm_en = 1'b1; snooze = 1'b0; dismiss = 1'b0;
    cyc(); cyc();
    chk("rst_ringing", 32'(ringing), 0);
    chk("rst_snoozing", 32'(snoozing), 0);
    chk("rst_ledr", 32'(LEDR), 0);
    chk("rst_alarm_hr", 32'(alarm_hr), 0);
    chk("rst_alarm_min", 32'(alarm_min), 0);
    reset = 1'b0;
    cyc();

    // T1: alarm 07:30, basic ring and auto-timeout
    set_alarm(1'b0, 30);
    set_alarm(1'b1, 7);
    chk("t1_alarm_min", 32'(alarm_min), 30);
    chk("t1_alarm_hr", 32'(alarm_hr), 7);
    do_tick(7, 29, 59);
    chk("t1_no_ring_early", 32'(ringing), 0);
    do_tick(7, 30, 0);
    chk("t1_ring_start", 32'(ringing), 1);
    chk("t1_ledr_on", 32'(LEDR), 32'h3FF);
    do_tick(7, 30, 1);
    chk("t1_ledr_tick1", 32'(LEDR), 32'h000);
    do_tick(7, 30, 2);
    chk("t1_ledr_tick2", 32'(LEDR), 32'h3FF);
    do_tick(7, 30, 3);
    do_tick(7, 30, 4);
    chk("t1_ring_tick4", 32'(ringing), 1);
    chk("t1_ledr_tick4", 32'(LEDR), 32'h3FF);
    do_tick(7, 30, 5);
    chk("t1_timeout", 32'(ringing), 0);
    chk("t1_timeout_ledr", 32'(LEDR), 0);

    // T2: snooze cycles and snooze limit
    do_tick(7, 30, 0);
    chk("t2_ring", 32'(ringing), 1);
    press_snooze();
    chk("t2_snz1", 32'(snoozing), 1);
    chk("t2_snz1_ring", 32'(ringing), 0);
    chk("t2_snz1_ledr", 32'(LEDR), 0);
    for (int i = 1; i <= 3; i++) do_tick(7, 31, i);
    chk("t2_still_snz", 32'(snoozing), 1);
    do_tick(7, 31, 4);
    chk("t2_resume", 32'(ringing), 1);
    chk("t2_resume_ledr", 32'(LEDR), 32'h3FF);
    press_snooze();
    chk("t2_snz2", 32'(snoozing), 1);
    for (int i = 5; i <= 8; i++) do_tick(7, 31, i);
    chk("t2_resume2", 32'(ringing), 1);
    press_snooze();
    chk("t2_snz3_ignored_ring", 32'(ringing), 1);
    chk("t2_snz3_ignored_snz", 32'(snoozing), 0);
    dismiss = 1'b1; cyc(); dismiss = 1'b0;
    chk("t2_dismiss", 32'(ringing), 0);

    // T3: dismiss beats snooze in the same cycle
    do_tick(7, 30, 0);
    chk("t3_ring", 32'(ringing), 1);
    dismiss = 1'b1; snooze = 1'b1;
    cyc();
    dismiss = 1'b0; snooze = 1'b0;
    chk("t3_ringing", 32'(ringing), 0);
    chk("t3_snoozing", 32'(snoozing), 0);
    chk("t3_ledr", 32'(LEDR), 0);
    cyc();

    // T4: range checks on alarm load
    set_alarm(1'b0, 60);
    chk("t4_min60", 32'(alarm_min), 30);
    set_alarm(1'b1, 24);
    chk("t4_hr24", 32'(alarm_hr), 7);
    set_alarm(1'b0, 59);
    chk("t4_min59", 32'(alarm_min), 59);
    set_alarm(1'b1, 23);
    chk("t4_hr23", 32'(alarm_hr), 23);

    // T5: midnight wrap, disarm, and disarm mid-snooze
    set_alarm(1'b0, 0);
    set_alarm(1'b1, 0);
    do_tick(23, 59, 59);
    chk("t5_pre_wrap", 32'(ringing), 0);
    do_tick(0, 0, 0);
    chk("t5_wrap_ring", 32'(ringing), 1);
    dismiss = 1'b1; cyc(); dismiss = 1'b0;
    alarm_en = 1'b0;
    do_tick(23, 59, 59);
    do_tick(0, 0, 0);
    chk("t5_disarmed", 32'(ringing), 0);
    alarm_en = 1'b1;
    do_tick(0, 0, 0);
    chk("t5_rearm_ring", 32'(ringing), 1);
    press_snooze();
    chk("t5_snz", 32'(snoozing), 1);
    alarm_en = 1'b0; cyc(); alarm_en = 1'b1;
    chk("t5_en_drop_snz", 32'(snoozing), 0);
    chk("t5_en_drop_ring", 32'(ringing), 0);

    // T6: reset while ringing, with snooze held through reset
    set_alarm(1'b0, 5);
    do_tick(0, 5, 0);
    chk("t6_ring", 32'(ringing), 1);
    snooze = 1'b1; reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t6_rst_ring", 32'(ringing), 0);
    chk("t6_rst_snz", 32'(snoozing), 0);
    chk("t6_rst_ledr", 32'(LEDR), 0);
    chk("t6_rst_min", 32'(alarm_min), 0);
    chk("t6_rst_hr", 32'(alarm_hr), 0);
    do_tick(0, 0, 0);
    chk("t6_ring_again", 32'(ringing), 1);
    cyc(); cyc();
    chk("t6_held_no_snz", 32'(snoozing), 0);
    chk("t6_held_still_ring", 32'(ringing), 1);
    snooze = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
